// File: rtl/trax_move_decoder.sv
// Trax notation line parser: turns a received ASCII byte stream into move words
// and colour assignments for the player core.
module trax_move_decoder #(
    parameter int COORD_W   = 10,
    parameter int MAX_COORD = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [2+2*COORD_W-1:0]   move_out,
    output logic                     move_valid,
    output logic                     end_receive,
    output logic                     color,
    output logic                     color_valid,
    output logic                     parse_err,
    output logic [2:0]               dbg_state
);
    localparam int MW    = 2 + 2 * COORD_W;
    localparam int ACC_W = COORD_W + 4;

    typedef enum logic [2:0] {
        LINE_START = 3'd0,
        COLOR      = 3'd1,
        ROW_FIRST  = 3'd2,
        ROW        = 3'd3,
        EOL        = 3'd4,
        SKIP       = 3'd5
    } state_t;

    // Handshake: a byte is consumed on every cycle rx_valid is high; there is no
    // backpressure. Output pulses appear the cycle after the triggering byte.
    state_t             state_q, state_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [1:0]         tile_q, tile_d;
    logic               pend_color_q, pend_color_d;
    logic               pend_move_q, pend_move_d;
    logic [MW-1:0]      move_out_q, move_out_d;
    logic               move_valid_q, move_valid_d;
    logic               end_receive_q, end_receive_d;
    logic               color_q, color_d;
    logic               color_valid_q, color_valid_d;
    logic               parse_err_q, parse_err_d;

    logic               is_digit, is_eol_char, err;
    logic [ACC_W-1:0]   row_ext, row_next;

    assign is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_eol_char = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign row_ext     = ACC_W'(row_q);
    assign row_next    = (row_ext << 3) + (row_ext << 1) + ACC_W'(rx_data[3:0]);

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        tile_d        = tile_q;
        pend_color_d  = pend_color_q;
        pend_move_d   = pend_move_q;
        move_out_d    = move_out_q;
        move_valid_d  = 1'b0;
        end_receive_d = end_receive_q;
        color_d       = color_q;
        color_valid_d = 1'b0;
        parse_err_d   = 1'b0;
        err           = 1'b0;

        if (rx_valid) begin
            case (state_q)
                LINE_START: begin
                    if (!is_eol_char) begin
                        end_receive_d = 1'b0;
                        if (rx_data == 8'h2D) begin
                            pend_move_d = 1'b0;
                            state_d     = COLOR;
                        end else if (rx_data >= 8'h40 && rx_data <= 8'h5A) begin
                            col_d       = COORD_W'(rx_data - 8'h40);
                            pend_move_d = 1'b1;
                            state_d     = ROW_FIRST;
                        end else begin
                            err = 1'b1;
                        end
                    end
                end
                COLOR: begin
                    if (rx_data == 8'h57 || rx_data == 8'h42) begin
                        pend_color_d = (rx_data == 8'h42);
                        state_d      = EOL;
                    end else begin
                        err = 1'b1;
                    end
                end
                ROW_FIRST: begin
                    if (is_digit) begin
                        row_d   = COORD_W'(rx_data[3:0]);
                        state_d = ROW;
                    end else begin
                        err = 1'b1;
                    end
                end
                ROW: begin
                    if (is_digit) begin
                        if (row_next > ACC_W'(MAX_COORD)) err = 1'b1;
                        else row_d = row_next[COORD_W-1:0];
                    end else if (rx_data == 8'h2B) begin
                        tile_d  = 2'b01;
                        state_d = EOL;
                    end else if (rx_data == 8'h2F) begin
                        tile_d  = 2'b10;
                        state_d = EOL;
                    end else if (rx_data == 8'h5C) begin
                        tile_d  = 2'b11;
                        state_d = EOL;
                    end else begin
                        err = 1'b1;
                    end
                end
                EOL: begin
                    if (rx_data == 8'h0A) begin
                        if (pend_move_q) begin
                            move_out_d    = {tile_q, col_q, row_q};
                            move_valid_d  = 1'b1;
                            end_receive_d = 1'b1;
                        end else begin
                            color_d       = pend_color_q;
                            color_valid_d = 1'b1;
                        end
                        col_d        = '0;
                        row_d        = '0;
                        tile_d       = '0;
                        pend_color_d = 1'b0;
                        pend_move_d  = 1'b0;
                        state_d      = LINE_START;
                    end else if (rx_data != 8'h0D) begin
                        err = 1'b1;
                    end
                end
                SKIP: begin
                    if (rx_data == 8'h0A) state_d = LINE_START;
                end
                default: state_d = LINE_START;
            endcase
        end

        // An error drops the whole line; SKIP then waits for its terminating LF.
        if (err) begin
            parse_err_d  = 1'b1;
            col_d        = '0;
            row_d        = '0;
            tile_d       = '0;
            pend_color_d = 1'b0;
            pend_move_d  = 1'b0;
            state_d      = SKIP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= LINE_START;
            col_q         <= '0;
            row_q         <= '0;
            tile_q        <= '0;
            pend_color_q  <= 1'b0;
            pend_move_q   <= 1'b0;
            move_out_q    <= '0;
            move_valid_q  <= 1'b0;
            end_receive_q <= 1'b0;
            color_q       <= 1'b0;
            color_valid_q <= 1'b0;
            parse_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            tile_q        <= tile_d;
            pend_color_q  <= pend_color_d;
            pend_move_q   <= pend_move_d;
            move_out_q    <= move_out_d;
            move_valid_q  <= move_valid_d;
            end_receive_q <= end_receive_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            parse_err_q   <= parse_err_d;
        end
    end

    assign move_out    = move_out_q;
    assign move_valid  = move_valid_q;
    assign end_receive = end_receive_q;
    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign parse_err   = parse_err_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_trax_move_decoder.sv
// Bench for trax_move_decoder: directed notation lines plus a random line stream,
// checked against a line-level grammar model and a scoreboard of move words.
// Directed strings use '|' for LF, '~' for CR and '^' for the backslash tile byte.
module tb_trax_move_decoder;
  localparam int ST_PART = 0;
  localparam int ST_DONE = 1;
  localparam int ST_BAD  = 2;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [21:0] move_out;
  logic        move_valid;
  logic        end_receive;
  logic        color;
  logic        color_valid;
  logic        parse_err;
  logic [2:0]  dbg_state;

  trax_move_decoder #(.COORD_W(10), .MAX_COORD(1023)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .move_out    (move_out),
    .move_valid  (move_valid),
    .end_receive (end_receive),
    .color       (color),
    .color_valid (color_valid),
    .parse_err   (parse_err),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  line_q[$];
  logic        m_skip;
  logic        exp_mv, exp_cv, exp_pe, exp_er, exp_color;
  logic [21:0] exp_move;
  logic [21:0] exp_q[$];
  int          mv_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Classify a line (without its LF) against the Trax line grammar.
  function automatic int classify(input logic [7:0] l[$], output logic is_move,
                                  output logic clr, output logic [21:0] word);
    int n;
    int i;
    int v;
    logic [1:0] t;
    n = l.size();
    is_move = 1'b0;
    clr     = 1'b0;
    word    = '0;
    t       = 2'b00;
    if (n == 0) return ST_PART;
    if (l[0] == 8'h2D) begin
      if (n == 1) return ST_PART;
      if (l[1] != 8'h57 && l[1] != 8'h42) return ST_BAD;
      clr = (l[1] == 8'h42);
      for (int k = 2; k < n; k++) if (l[k] != 8'h0D) return ST_BAD;
      return ST_DONE;
    end
    if (l[0] < 8'h40 || l[0] > 8'h5A) return ST_BAD;
    is_move = 1'b1;
    i = 1;
    v = 0;
    while (i < n && l[i] >= 8'h30 && l[i] <= 8'h39) begin
      v = v * 10 + int'(l[i]) - 48;
      if (v > 1023) return ST_BAD;
      i++;
    end
    if (i == 1) return (n == 1) ? ST_PART : ST_BAD;
    if (i == n) return ST_PART;
    if (l[i] == 8'h2B) t = 2'b01;
    else if (l[i] == 8'h2F) t = 2'b10;
    else if (l[i] == 8'h5C) t = 2'b11;
    else return ST_BAD;
    for (int k = i + 1; k < n; k++) if (l[k] != 8'h0D) return ST_BAD;
    word = {t, 10'(int'(l[0]) - 64), 10'(v)};
    return ST_DONE;
  endfunction

  task automatic model_reset();
    line_q.delete();
    exp_q.delete();
    m_skip    = 1'b0;
    exp_mv    = 1'b0;
    exp_cv    = 1'b0;
    exp_pe    = 1'b0;
    exp_er    = 1'b0;
    exp_color = 1'b0;
    exp_move  = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int st;
    logic im, c;
    logic [21:0] w;
    exp_mv = 1'b0;
    exp_cv = 1'b0;
    exp_pe = 1'b0;
    if (m_skip) begin
      if (b == 8'h0A) m_skip = 1'b0;
      return;
    end
    if (line_q.size() == 0 && (b == 8'h0D || b == 8'h0A)) return;
    if (line_q.size() == 0) exp_er = 1'b0;
    if (b == 8'h0A) begin
      st = classify(line_q, im, c, w);
      if (st == ST_DONE) begin
        if (im) begin
          exp_move = w;
          exp_mv   = 1'b1;
          exp_er   = 1'b1;
          exp_q.push_back(w);
        end else begin
          exp_color = c;
          exp_cv    = 1'b1;
        end
      end else begin
        exp_pe = 1'b1;
        m_skip = 1'b1;
      end
      line_q.delete();
      return;
    end
    line_q.push_back(b);
    st = classify(line_q, im, c, w);
    if (st == ST_BAD) begin
      exp_pe = 1'b1;
      m_skip = 1'b1;
      line_q.delete();
    end
  endtask

  // Scoreboard and per-cycle output checks
  task automatic check_outputs();
    check("move_valid", move_valid, exp_mv);
    check("color_valid", color_valid, exp_cv);
    check("parse_err", parse_err, exp_pe);
    check("end_receive", end_receive, exp_er);
    check("move_out", move_out, exp_move);
    check("color", color, exp_color);
    if (move_valid) begin
      mv_cyc.push_back(cyc);
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sb_word", move_out, exp_q.pop_front());
    end
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    exp_mv   = 1'b0;
    exp_cv   = 1'b0;
    exp_pe   = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [7:0] map_char(input logic [7:0] ch);
    if (ch == 8'h7C) return 8'h0A;
    if (ch == 8'h7E) return 8'h0D;
    if (ch == 8'h5E) return 8'h5C;
    return ch;
  endfunction

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(map_char(s[i]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_line();
    logic [7:0] q[$];
    int kind;
    int nd;
    int pos;
    logic [7:0] tiles[3];
    tiles[0] = 8'h2B;
    tiles[1] = 8'h2F;
    tiles[2] = 8'h5C;
    kind = $urandom_range(0, 9);
    if (kind <= 5 || kind == 8) begin
      q.push_back(8'(8'h40 + $urandom_range(0, 26)));
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
      q.push_back(tiles[$urandom_range(0, 2)]);
      if (kind == 8) begin
        pos = $urandom_range(0, q.size());
        q.insert(pos, 8'($urandom_range(0, 127)));
      end
    end else if (kind <= 7) begin
      q.push_back(8'h2D);
      q.push_back(($urandom_range(0, 1) == 1) ? 8'h42 : 8'h57);
    end
    if ($urandom_range(0, 2) == 0) q.push_back(8'h0D);
    q.push_back(8'h0A);
    for (int i = 0; i < q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_byte(q[i]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    do_reset();
    check("rst_move_out", move_out, 22'd0);
    check("rst_end_receive", end_receive, 0);

    send_str("A1+|");
    check("tp_a1", move_out, {2'b01, 10'd1, 10'd1});
    check("tp_a1_er", end_receive, 1);
    idle();
    idle();
    send_str("@0/~|");
    check("tp_at0", move_out, {2'b10, 10'd0, 10'd0});
    send_str("B12^|");
    check("tp_b12", move_out, {2'b11, 10'd2, 10'd12});
    send_str("-B|");
    check("tp_color_b", color, 1);
    check("tp_color_er", end_receive, 0);
    send_str("-W|");
    check("tp_color_w", color, 0);

    send_str("A1x");
    check("tp_err_x", parse_err, 1);
    send_str("|A102");
    send_byte(8'h34);
    check("tp_err_ovf", parse_err, 1);
    send_str("+|A007+|");
    check("tp_lead0", move_out, {2'b01, 10'd1, 10'd7});
    send_str("C3/|");
    check("tp_c3", move_out, {2'b10, 10'd3, 10'd3});

    mv_cyc.delete();
    send_str("A1+|B2/|");
    check("stream_pulses", mv_cyc.size(), 2);
    if (mv_cyc.size() == 2) check("stream_gap", mv_cyc[1] - mv_cyc[0], 4);
    check("stream_word", move_out, {2'b10, 10'd2, 10'd2});
    send_byte(8'h43);
    check("stream_er_clear", end_receive, 0);
    send_str("9+|");

    send_str("A1");
    do_reset();
    send_byte(8'h2B);
    check("tp_rst_pe", parse_err, 1);
    send_byte(8'h0A);
    check("tp_rst_move", move_out, 22'd0);
    check("tp_rst_mv", move_valid, 0);

    for (int n = 0; n < 400; n++) begin
      rand_line();
      if ($urandom_range(0, 39) == 0) begin
        send_byte(8'(8'h41 + $urandom_range(0, 5)));
        do_reset();
      end
    end
    idle();
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
